// File: rtl/md_sequencer_if.sv
// ---------------------------------------------------------------------------
// md_sequencer_if
//
// Signal bundle between the multiply/divide sequencer, the control unit and
// the two iterative arithmetic units (multiplier, divider).
//
//   Requests (control unit -> sequencer)
//     mult_start, div_start, div_zero, mf_req, mthi, mtlo, mt_data[31:0]
//   Unit results (units -> sequencer)
//     mult_hi[31:0], mult_lo[31:0], div_hi[31:0] (remainder),
//     div_lo[31:0] (quotient)
//   Sequencer outputs
//     md_init, div_init     one-cycle init pulses to the units
//     hi[31:0], lo[31:0]    architectural Hi/Lo registers
//     busy, done, div0_exc, stall
//
// Modports:
//   master - the environment side (control unit + arithmetic units)
//   slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface md_sequencer_if;

    // Requests from the control unit
    logic        mult_start;
    logic        div_start;
    logic        div_zero;
    logic        mf_req;
    logic        mthi;
    logic        mtlo;
    logic [31:0] mt_data;

    // Results from the arithmetic units
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    // Sequencer outputs
    logic        md_init;
    logic        div_init;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0_exc;
    logic        stall;

    modport master (
        output mult_start, div_start, div_zero, mf_req, mthi, mtlo, mt_data,
        output mult_hi, mult_lo, div_hi, div_lo,
        input  md_init, div_init, hi, lo, busy, done, div0_exc, stall
    );

    modport slave (
        input  mult_start, div_start, div_zero, mf_req, mthi, mtlo, mt_data,
        input  mult_hi, mult_lo, div_hi, div_lo,
        output md_init, div_init, hi, lo, busy, done, div0_exc, stall
    );

endinterface

// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//
// Controller for the shared multiply/divide resource. A start request from
// the control unit launches the selected unit with a one-cycle init pulse,
// the sequencer then counts the unit's iteration cycles and finally commits
// the unit's result into the architectural Hi/Lo registers. mthi/mtlo writes
// are accepted only while idle, and the pipeline is stalled whenever it asks
// for the resource (or for Hi/Lo) while an operation is in flight.
//
// Parameters:
//   MULT_CYCLES  cycles the multiplier needs after init (>= 1)
//   DIV_CYCLES   cycles the divider needs after init (>= 1)
//   CNT_W        iteration counter width, must hold max(MULT_CYCLES,DIV_CYCLES)
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous, active-high
//   bus    md_sequencer_if.slave - requests, unit results, Hi/Lo and status
//
// Timing summary for an operation taking N unit cycles:
//   start edge -> N cycles in RUN (init pulse in the first) -> 1 cycle WB
//   -> IDLE with done high for one cycle and the new Hi/Lo visible.
//   busy is therefore high for N+1 cycles.
// ---------------------------------------------------------------------------
module md_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic            clk,
    input  logic            reset,
    md_sequencer_if.slave   bus
);

    // -----------------------------------------------------------------------
    // Types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    // Operation select doubles as the index into the per-unit tables below.
    localparam int   NUM_UNITS = 2;
    localparam logic OP_MULT   = 1'b0;
    localparam logic OP_DIV    = 1'b1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_reg,  state_next;
    logic               op_reg,     op_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;
    logic [31:0]        hi_reg,     hi_next;
    logic [31:0]        lo_reg,     lo_next;
    logic               done_reg,   done_next;
    logic               div0_reg,   div0_next;

    // -----------------------------------------------------------------------
    // Per-unit views: load value, result words and init pulse, indexed by op
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]   unit_load [NUM_UNITS];
    logic [31:0]        unit_hi   [NUM_UNITS];
    logic [31:0]        unit_lo   [NUM_UNITS];
    logic [NUM_UNITS-1:0] init_vec;

    assign unit_load[0] = MULT_LOAD;
    assign unit_load[1] = DIV_LOAD;
    assign unit_hi[0]   = bus.mult_hi;
    assign unit_hi[1]   = bus.div_hi;
    assign unit_lo[0]   = bus.mult_lo;
    assign unit_lo[1]   = bus.div_lo;

    // The counter still holds its load value only in the first RUN cycle,
    // so comparing against it yields exactly one init pulse per operation
    // without a separate "first cycle" flag.
    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit_init
            assign init_vec[gi] = (state_reg == RUN)
                               && (op_reg == 1'(gi))
                               && (cnt_reg == unit_load[gi]);
        end
    endgenerate

    // Result word of the unit that owns the current operation.
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;

    assign wb_hi = unit_hi[op_reg];
    assign wb_lo = unit_lo[op_reg];

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;
        div0_next  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // Moves to Hi/Lo are independent of a start on the same
                // edge; a started operation overwrites both at WB anyway.
                if (bus.mthi) begin
                    hi_next = bus.mt_data;
                end
                if (bus.mtlo) begin
                    lo_next = bus.mt_data;
                end

                // Multiply wins over divide; a losing divide is dropped.
                if (bus.mult_start) begin
                    op_next    = OP_MULT;
                    cnt_next   = MULT_LOAD;
                    state_next = RUN;
                end else if (bus.div_start && !bus.div_zero) begin
                    op_next    = OP_DIV;
                    cnt_next   = DIV_LOAD;
                    state_next = RUN;
                end else if (bus.div_start) begin
                    // Divide by zero never occupies the resource: flag the
                    // exception and complete immediately, Hi/Lo untouched.
                    done_next = 1'b1;
                    div0_next = 1'b1;
                end
            end

            RUN: begin
                // Saturate at zero so a corrupted count can never wrap and
                // lock the sequencer in RUN; a count of 0 or 1 ends RUN.
                if (cnt_reg != CNT_ZERO) begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
                if (cnt_reg <= CNT_ONE) begin
                    state_next = WB;
                end
            end

            WB: begin
                hi_next    = wb_hi;
                lo_next    = wb_lo;
                done_next  = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= OP_MULT;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
            div0_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            done_reg  <= done_next;
            div0_reg  <= div0_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    logic busy;

    assign busy = (state_reg != IDLE);

    assign bus.md_init  = init_vec[OP_MULT];
    assign bus.div_init = init_vec[OP_DIV];
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.busy     = busy;
    assign bus.done     = done_reg;
    assign bus.div0_exc = div0_reg;

    // Any request that needs the resource or a stable Hi/Lo is held off
    // while an operation is in flight; in IDLE nothing ever stalls.
    assign bus.stall = busy & (bus.mult_start | bus.div_start | bus.mf_req
                             | bus.mthi | bus.mtlo);

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Controller for the shared multiply/divide resource of the datapath. It accepts mult/div requests from the control unit and issues a one-cycle init pulse to the selected unit. It counts the unit's iteration cycles, then commits the unit's result into the architectural Hi/Lo registers. It also serialises mthi/mtlo/mfhi/mflo accesses and raises a stall to the pipeline while the resource is busy.

Parameters:
MULT_CYCLES, 32, cycles the multiplier needs after init before its outputs are valid (min 1)
DIV_CYCLES, 32, cycles the divider needs after init before its outputs are valid (min 1)
CNT_W, 6, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
mult_start  in  1  request signed multiply (level, sampled each edge)
div_start  in  1  request signed divide
div_zero  in  1  divisor == 0, qualified by div_start
mf_req  in  1  mfhi/mflo in decode, needs stable Hi/Lo
mthi  in  1  write mt_data to Hi
mtlo  in  1  write mt_data to Lo
mt_data  in  32  data for mthi/mtlo
mult_hi  in  32  multiplier upper result
mult_lo  in  32  multiplier lower result
div_hi  in  32  divider remainder
div_lo  in  32  divider quotient
md_init  out  1  MDControl to multiplier, one-cycle pulse
div_init  out  1  init to divider, one-cycle pulse
hi  out  32  architectural Hi register
lo  out  32  architectural Lo register
busy  out  1  operation in flight
done  out  1  one-cycle pulse, Hi/Lo just updated
div0_exc  out  1  one-cycle pulse, divide by zero
stall  out  1  pipeline stall request

Behaviour:
- Reset (any state, including mid-operation): state=IDLE, counter=0, hi=lo=0, md_init=div_init=done=div0_exc=0, busy=stall=0. No init pulse is issued in the cycle after reset.
- States: IDLE, RUN, WB.
- IDLE, rising edge:
  - mult_start=1: op<=MULT, cnt<=MULT_CYCLES, go to RUN.
  - else div_start=1 and div_zero=0: op<=DIV, cnt<=DIV_CYCLES, go to RUN.
  - else div_start=1 and div_zero=1: stay IDLE; next cycle div0_exc=1 and done=1 for one cycle; hi/lo unchanged.
  - mult_start has priority when both starts are high; div_start is dropped, not queued.
- RUN:
  - md_init (op=MULT) or div_init (op=DIV) is high only in the first RUN cycle (cnt == loaded value).
  - Each edge: cnt<=cnt-1. At the edge where cnt==1, go to WB. RUN therefore lasts exactly N cycles.
- WB (one cycle): at its closing edge, hi<=mult_hi/div_hi and lo<=mult_lo/div_lo per op. State<=IDLE, done<=1.
- done is registered: high for the single cycle after WB, when new hi/lo are already visible.
- busy = (state != IDLE). From the start edge, busy is high for N+1 cycles.
- mthi/mtlo, IDLE only: hi/lo <= mt_data at the edge.
  - mthi and mtlo together write both.
  - Also accepted on the same edge as a start. The operation's WB later overwrites both.
- stall = busy & (mult_start | div_start | mf_req | mthi | mtlo). Combinational, no stall in IDLE.
- Requests arriving while busy are ignored by the sequencer. The control unit holds them under stall, so they are accepted in the first IDLE cycle (the done cycle).
- Operand/result widths: pass-through 32 bits. No arithmetic in this block besides the counter decrement. The counter never wraps below 0.

Test Plan:
- Reset, then mult_start one cycle with stub unit giving mult_hi=32'hFFFFFFFF, mult_lo=32'hFFFFFFEB (7 x -3) -> md_init high exactly 1 cycle; busy high 33 cycles; done pulse with hi=FFFFFFFF, lo=FFFFFFEB.
- div_start with div_zero=0, div_lo=5, div_hi=2 (17/3) -> div_init 1 cycle, md_init never high; done after DIV_CYCLES+1 cycles; hi=2, lo=5. Then div_start with div_zero=1 -> busy stays 0; next cycle div0_exc=1, done=1; hi=2, lo=5 unchanged.
- mult_start and div_start asserted on the same edge -> only md_init pulses; result taken from mult_hi/mult_lo.
- mult in flight, mf_req held high from cycle 3 -> stall=1 until WB ends; stall=0 in the done cycle. mthi with mt_data=32'hA5A5A5A5 during RUN is ignored; the same mthi in IDLE gives hi=A5A5A5A5 at the next cycle.
- reset asserted at cycle 10 of a 32-cycle mult -> next cycle busy=0, hi=lo=0; no done pulse. A fresh mult_start afterwards completes normally with full latency.
